// File: rtl/pipeline_run_controller.sv
// Run/halt/step sequencer for the three-stage instruction pipeline: post-reset flush,
// shared clock-enable, NOP-inject strobe, sticky break status and enabled-cycle counter.
module pipeline_run_controller #(
    parameter int FLUSH_CYCLES  = 3,
    parameter bit START_RUNNING = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             ClockIn,
    input  logic             ResetIn_n,
    input  logic             BreakIn,
    input  logic             RunReq,
    input  logic             HaltReq,
    input  logic             StepReq,
    output logic             PipeEnable,
    output logic             NopInject,
    output logic             Running,
    output logic             Halted,
    output logic             BreakHit,
    output logic [CNT_W-1:0] CycleCount
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } runState_t;

    runState_t       state;
    runState_t       stateNext;
    logic [FC_W-1:0] flushCnt;
    logic [FC_W-1:0] flushCntNext;
    logic            breakMask;
    logic            breakMaskNext;
    logic            breakHitNext;
    logic            stepReq_p1;
    logic            stepEdge;

    assign stepEdge = StepReq & ~stepReq_p1;

    always_comb begin
        stateNext     = state;
        flushCntNext  = flushCnt;
        breakMaskNext = 1'b0;
        breakHitNext  = BreakHit;
        case (state)
            FLUSH: begin
                if (flushCnt == FLUSH_LAST) begin
                    stateNext    = START_RUNNING ? RUN : HALTED;
                    flushCntNext = '0;
                end else begin
                    flushCntNext = flushCnt + 1'b1;
                end
            end
            RUN: begin
                if (HaltReq) begin
                    stateNext    = HALTED;
                    breakHitNext = 1'b0;
                end else if (BreakIn && !breakMask) begin
                    stateNext    = HALTED;
                    breakHitNext = 1'b1;
                end
            end
            HALTED: begin
                // The break word is still frozen in stage 2 on the first enabled cycle after
                // resuming, so the mask keeps it from re-halting straight away.
                if (HaltReq) begin
                    stateNext = HALTED;
                end else if (stepEdge) begin
                    stateNext     = STEP;
                    breakMaskNext = 1'b1;
                    breakHitNext  = 1'b0;
                end else if (RunReq) begin
                    stateNext     = RUN;
                    breakMaskNext = 1'b1;
                    breakHitNext  = 1'b0;
                end
            end
            STEP: begin
                stateNext = HALTED;
                if (BreakIn) begin
                    breakHitNext = 1'b1;
                end
            end
            default: begin
                stateNext = FLUSH;
            end
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (!ResetIn_n) begin
            state      <= FLUSH;
            flushCnt   <= '0;
            CycleCount <= '0;
            BreakHit   <= 1'b0;
            stepReq_p1 <= 1'b0;
            breakMask  <= 1'b0;
        end else begin
            state      <= stateNext;
            flushCnt   <= flushCntNext;
            BreakHit   <= breakHitNext;
            stepReq_p1 <= StepReq;
            breakMask  <= breakMaskNext;
            if (PipeEnable) begin
                CycleCount <= CycleCount + 1'b1;
            end
        end
    end

    assign PipeEnable = (state != HALTED);
    assign NopInject  = (state == FLUSH);
    assign Running    = (state == RUN);
    assign Halted     = (state == HALTED);

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller with a cycle-level behavioural model,
// checking a 16-bit-counter instance and a 4-bit-counter instance driven in parallel.
module tb_pipeline_run_controller;

    localparam int FLUSH_N  = 3;
    localparam int M_FLUSH  = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;
    localparam int M_STEP   = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic        brk;
    logic        runReq;
    logic        haltReq;
    logic        stepReq;

    logic        pipeEn, nop, running, halted, breakHit;
    logic [15:0] cnt;
    logic        pipeEn4, nop4, running4, halted4, breakHit4;
    logic [3:0]  cnt4;

    int checks = 0;
    int failures = 0;

    int mMode;
    int mFlushLeft;
    int mCount;
    bit mBrk;
    bit mStepPrev;
    bit mResumed;
    bit mValid = 1'b0;

    always #5 clk = ~clk;

    pipeline_run_controller #(
        .FLUSH_CYCLES(FLUSH_N), .START_RUNNING(1'b1), .CNT_W(16)
    ) dut (
        .ClockIn(clk), .ResetIn_n(rstN), .BreakIn(brk), .RunReq(runReq),
        .HaltReq(haltReq), .StepReq(stepReq), .PipeEnable(pipeEn),
        .NopInject(nop), .Running(running), .Halted(halted),
        .BreakHit(breakHit), .CycleCount(cnt)
    );

    pipeline_run_controller #(
        .FLUSH_CYCLES(FLUSH_N), .START_RUNNING(1'b1), .CNT_W(4)
    ) dut4 (
        .ClockIn(clk), .ResetIn_n(rstN), .BreakIn(brk), .RunReq(runReq),
        .HaltReq(haltReq), .StepReq(stepReq), .PipeEnable(pipeEn4),
        .NopInject(nop4), .Running(running4), .Halted(halted4),
        .BreakHit(breakHit4), .CycleCount(cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Model: compares what the DUT shows after the last rising edge, then predicts the
    // next edge from the inputs that edge will sample (inputs settle 2 units after posedge).
    initial begin
        bit stepRise;
        bit resumedNext;
        forever begin
            @(negedge clk);
            if (mValid) begin
                check("PipeEnable", pipeEn, mMode != M_HALTED);
                check("NopInject", nop, mMode == M_FLUSH);
                check("Running", running, mMode == M_RUN);
                check("Halted", halted, mMode == M_HALTED);
                check("BreakHit", breakHit, mBrk);
                check("CycleCount", cnt, mCount & 32'hFFFF);
                check("PipeEnable4", pipeEn4, mMode != M_HALTED);
                check("Running4", running4, mMode == M_RUN);
                check("Halted4", halted4, mMode == M_HALTED);
                check("BreakHit4", breakHit4, mBrk);
                check("NopInject4", nop4, mMode == M_FLUSH);
                check("CycleCount4", cnt4, mCount & 32'hF);
            end
            if (!rstN) begin
                mMode      = M_FLUSH;
                mFlushLeft = FLUSH_N;
                mCount     = 0;
                mBrk       = 1'b0;
                mStepPrev  = 1'b0;
                mResumed   = 1'b0;
                mValid     = 1'b1;
            end else if (mValid) begin
                stepRise    = stepReq && !mStepPrev;
                mStepPrev   = stepReq;
                resumedNext = 1'b0;
                if (mMode != M_HALTED) mCount++;
                if (mMode == M_FLUSH) begin
                    mFlushLeft--;
                    if (mFlushLeft == 0) mMode = M_RUN;
                end else if (mMode == M_RUN) begin
                    if (haltReq) begin
                        mMode = M_HALTED;
                        mBrk  = 1'b0;
                    end else if (brk && !mResumed) begin
                        mMode = M_HALTED;
                        mBrk  = 1'b1;
                    end
                end else if (mMode == M_STEP) begin
                    if (brk) mBrk = 1'b1;
                    mMode = M_HALTED;
                end else if (!haltReq && (stepRise || runReq)) begin
                    mMode       = stepRise ? M_STEP : M_RUN;
                    mBrk        = 1'b0;
                    resumedNext = 1'b1;
                end
                mResumed = resumedNext;
            end
        end
    end

    initial begin
        rstN = 1'b0; brk = 1'b0; runReq = 1'b0; haltReq = 1'b0; stepReq = 1'b0;
        tick(2);
        check("rst_nop", nop, 1'b1);
        check("rst_pipeEn", pipeEn, 1'b1);
        check("rst_running", running, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_count", cnt, 0);

        rstN = 1'b1;
        tick(2);
        check("flush_nop", nop, 1'b1);
        check("flush_count", cnt, 2);
        tick(1);
        check("run_after_flush", running, 1'b1);
        check("run_nop", nop, 1'b0);
        check("count_after_flush", cnt, 3);
        tick(14);
        check("count17", cnt, 17);
        check("count4_wrap", cnt4, 1);

        brk = 1'b1;
        tick(1);
        brk = 1'b0;
        check("brk_halted", halted, 1'b1);
        check("brk_hit", breakHit, 1'b1);
        check("brk_pipeEn", pipeEn, 1'b0);
        check("brk_count", cnt, 18);
        tick(2);
        check("halted_count", cnt, 18);

        runReq = 1'b1; brk = 1'b1;
        tick(1);
        check("resume_running", running, 1'b1);
        check("resume_brkhit", breakHit, 1'b0);
        tick(1);
        check("masked_running", running, 1'b1);
        check("masked_count", cnt, 19);
        brk = 1'b0; runReq = 1'b0;
        tick(1);
        check("run_count", cnt, 20);

        haltReq = 1'b1;
        tick(1);
        haltReq = 1'b0;
        check("halt_halted", halted, 1'b1);
        check("halt_brkhit", breakHit, 1'b0);
        check("halt_count", cnt, 21);
        stepReq = 1'b1;
        tick(5);
        check("step_halted", halted, 1'b1);
        check("step_count", cnt, 22);
        stepReq = 1'b0;
        tick(1);

        runReq = 1'b1;
        tick(3);
        check("rh_pre_count", cnt, 24);
        haltReq = 1'b1;
        tick(3);
        check("rh_halted", halted, 1'b1);
        check("rh_brkhit", breakHit, 1'b0);
        check("rh_count", cnt, 25);
        haltReq = 1'b0;
        tick(1);
        check("rh_resume", running, 1'b1);
        tick(1);

        stepReq = 1'b1;
        tick(2);
        runReq = 1'b0; haltReq = 1'b1;
        tick(1);
        haltReq = 1'b0;
        tick(3);
        check("stale_step_halted", halted, 1'b1);
        check("stale_step_count", cnt, 29);
        stepReq = 1'b0;

        runReq = 1'b1;
        tick(2);
        check("pre_rst_count", cnt, 30);
        rstN = 1'b0; runReq = 1'b0;
        tick(1);
        check("rstrun_count", cnt, 0);
        check("rstrun_nop", nop, 1'b1);
        check("rstrun_running", running, 1'b0);
        rstN = 1'b1;
        tick(3);
        check("reflush_running", running, 1'b1);
        check("reflush_count", cnt, 3);

        brk = 1'b1;
        tick(1);
        check("brk2_hit", breakHit, 1'b1);
        rstN = 1'b0; brk = 1'b0;
        tick(1);
        check("rsthalt_brkhit", breakHit, 1'b0);
        check("rsthalt_count", cnt, 0);
        rstN = 1'b1;
        tick(3);

        brk = 1'b1;
        tick(1);
        brk = 1'b0; stepReq = 1'b1;
        tick(1);
        check("instep_pipeEn", pipeEn, 1'b1);
        check("instep_halted", halted, 1'b0);
        check("instep_running", running, 1'b0);
        check("instep_count", cnt, 4);
        rstN = 1'b0; stepReq = 1'b0;
        tick(1);
        check("rststep_count", cnt, 0);
        check("rststep_nop", nop, 1'b1);
        check("rststep_brkhit", breakHit, 1'b0);
        rstN = 1'b1;
        tick(3);
        check("final_running", running, 1'b1);
        check("final_count", cnt, 3);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
